// File: rtl/trap_if.sv
// trap_if: bundles the trap_sequencer request, CSR handshake and status signals.
// master: pipeline/CSR side driving requests and csr_ack; slave: the sequencer.
interface trap_if #(
  parameter int NUM_EXC = 4,
  parameter int CNT_W   = 16
);
  logic [NUM_EXC-1:0]    exc_valid;
  logic [NUM_EXC*32-1:0] exc_cause;
  logic [NUM_EXC*32-1:0] exc_pc;
  logic                  irq_pending;
  logic [31:0]           irq_cause;
  logic                  mret_req;
  logic [31:0]           retire_pc;
  logic                  pipe_idle;
  logic                  csr_ack;
  logic                  stall;
  logic                  trap_commit;
  logic                  mret_commit;
  logic                  trap_is_irq;
  logic [31:0]           trap_cause;
  logic [31:0]           trap_epc;
  logic                  flush;
  logic                  busy;
  logic [CNT_W-1:0]      trap_count;
  modport master (
    output exc_valid, exc_cause, exc_pc, irq_pending, irq_cause, mret_req,
           retire_pc, pipe_idle, csr_ack,
    input  stall, trap_commit, mret_commit, trap_is_irq, trap_cause, trap_epc,
           flush, busy, trap_count
  );
  modport slave (
    input  exc_valid, exc_cause, exc_pc, irq_pending, irq_cause, mret_req,
           retire_pc, pipe_idle, csr_ack,
    output stall, trap_commit, mret_commit, trap_is_irq, trap_cause, trap_epc,
           flush, busy, trap_count
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions, the external interrupt and mret, drains
// the pipeline, hands one captured commit to the CSR unit (req/ack), then flushes.
// Ports: clk, reset (async, active-high), bus (trap_if.slave: requests in,
// stall/commit/cause/epc/flush/busy/trap_count out).
module trap_sequencer #(
  parameter int NUM_EXC      = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic   clk,
  input logic   reset,
  trap_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, FLUSH} state_t;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_CYCLES - 1);
  state_t           state, state_n;
  logic [DW-1:0]    drain_cnt, drain_n;
  logic             mret_f, mret_n;
  logic             is_irq, irq_n;
  logic [31:0]      cause, cause_n, epc, epc_n;
  logic [CNT_W-1:0] count, count_n;
  logic [31:0]      sel_cause, sel_pc;
  logic             exc_any;
  assign exc_any = |bus.exc_valid;
  always_comb begin
    sel_cause = '0;
    sel_pc = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--)
      if (bus.exc_valid[i]) begin
        sel_cause = bus.exc_cause[32*i +: 32];
        sel_pc = bus.exc_pc[32*i +: 32];
      end
  end
  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    mret_n = mret_f;
    irq_n = is_irq;
    cause_n = cause;
    epc_n = epc;
    count_n = count;
    case (state)
      IDLE:
        if (exc_any) begin
          state_n = COMMIT;
          cause_n = sel_cause & 32'h7fff_ffff;
          epc_n = sel_pc;
          irq_n = 1'b0;
          mret_n = 1'b0;
        end else if (bus.irq_pending) begin
          state_n = DRAIN;
          drain_n = '0;
          irq_n = 1'b1;
          mret_n = 1'b0;
        end else if (bus.mret_req) begin
          state_n = COMMIT;
          mret_n = 1'b1;
          irq_n = 1'b0;
        end
      DRAIN: begin
        // Saturating at the threshold keeps a long drain from wrapping the count.
        drain_n = drain_cnt == DLAST ? drain_cnt : drain_cnt + 1'b1;
        if (exc_any) begin
          state_n = COMMIT;
          cause_n = sel_cause & 32'h7fff_ffff;
          epc_n = sel_pc;
          irq_n = 1'b0;
        end else if (!bus.irq_pending) begin
          state_n = IDLE;
        end else if (bus.pipe_idle && drain_cnt >= DLAST) begin
          state_n = COMMIT;
          cause_n = bus.irq_cause | 32'h8000_0000;
          epc_n = bus.retire_pc;
        end
      end
      COMMIT:
        if (bus.csr_ack) begin
          state_n = FLUSH;
          count_n = (!mret_f && count != '1) ? count + 1'b1 : count;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      drain_cnt <= '0;
      mret_f <= 1'b0;
      is_irq <= 1'b0;
      cause <= '0;
      epc <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      drain_cnt <= drain_n;
      mret_f <= mret_n;
      is_irq <= irq_n;
      cause <= cause_n;
      epc <= epc_n;
      count <= count_n;
    end
  assign bus.stall = state != IDLE;
  assign bus.busy = state != IDLE;
  assign bus.trap_commit = state == COMMIT && !mret_f;
  assign bus.mret_commit = state == COMMIT && mret_f;
  assign bus.flush = state == FLUSH;
  assign bus.trap_is_irq = is_irq;
  assign bus.trap_cause = cause;
  assign bus.trap_epc = epc;
  assign bus.trap_count = count;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: randomized transaction-level check of trap_sequencer, with a
// second CNT_W=2 instance fed the same stimulus to observe counter saturation.
module tb_trap_sequencer;
  localparam int NE = 4;
  localparam int DC = 2;
  logic clk = 0;
  logic reset = 1;
  logic [NE-1:0] exc_valid = '0;
  logic [NE*32-1:0] exc_cause = '0, exc_pc = '0;
  logic irq_pending = 0, mret_req = 0, pipe_idle = 0, csr_ack = 0;
  logic [31:0] irq_cause = '0, retire_pc = '0;
  int checks = 0, errors = 0;
  int m_count = 0;
  logic [31:0] m_cause = '0, m_epc = '0;
  trap_if #(.NUM_EXC(NE), .CNT_W(16)) b0 ();
  trap_if #(.NUM_EXC(NE), .CNT_W(2)) b1 ();
  assign b0.exc_valid = exc_valid;
  assign b0.exc_cause = exc_cause;
  assign b0.exc_pc = exc_pc;
  assign b0.irq_pending = irq_pending;
  assign b0.irq_cause = irq_cause;
  assign b0.mret_req = mret_req;
  assign b0.retire_pc = retire_pc;
  assign b0.pipe_idle = pipe_idle;
  assign b0.csr_ack = csr_ack;
  assign b1.exc_valid = exc_valid;
  assign b1.exc_cause = exc_cause;
  assign b1.exc_pc = exc_pc;
  assign b1.irq_pending = irq_pending;
  assign b1.irq_cause = irq_cause;
  assign b1.mret_req = mret_req;
  assign b1.retire_pc = retire_pc;
  assign b1.pipe_idle = pipe_idle;
  assign b1.csr_ack = csr_ack;
  trap_sequencer #(.NUM_EXC(NE), .DRAIN_CYCLES(DC), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b0.slave));
  trap_sequencer #(.NUM_EXC(NE), .DRAIN_CYCLES(DC), .CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_regs;
    check("cause", b0.trap_cause, m_cause);
    check("epc", b0.trap_epc, m_epc);
    check("count", b0.trap_count, 64'(m_count));
    check("count_sat", b1.trap_count, 64'(m_count > 3 ? 3 : m_count));
  endtask
  task automatic check_idle;
    check("idle_busy", b0.busy, 0);
    check("idle_stall", b0.stall, 0);
    check("idle_flush", b0.flush, 0);
    check("idle_trap", b0.trap_commit, 0);
    check("idle_mret", b0.mret_commit, 0);
    check_regs();
  endtask
  task automatic idle_inputs;
    exc_valid = '0;
    irq_pending = 0;
    mret_req = 0;
    csr_ack = 0;
    pipe_idle = 1'($urandom);
  endtask
  task automatic noise;
    exc_valid = NE'($urandom);
    irq_pending = 1'($urandom);
    mret_req = 1'($urandom);
    irq_cause = $urandom;
    retire_pc = $urandom;
  endtask
  task automatic finish_commit(input bit is_mret, input bit irq, input int ack);
    for (int d = 0; d <= ack; d++) begin
      check("commit_trap", b0.trap_commit, !is_mret);
      check("commit_mret", b0.mret_commit, is_mret);
      check("commit_stall", b0.stall, 1);
      check("commit_flush", b0.flush, 0);
      if (!is_mret) check("commit_irq", b0.trap_is_irq, irq);
      check_regs();
      noise();
      csr_ack = (d == ack);
      step();
    end
    if (!is_mret) m_count++;
    check("flush", b0.flush, 1);
    check("flush_stall", b0.stall, 1);
    check("flush_trap", b0.trap_commit, 0);
    check("flush_mret", b0.mret_commit, 0);
    check_regs();
    noise();
    csr_ack = 1'($urandom);
    step();
    idle_inputs();
    check_idle();
  endtask
  task automatic capture_exc(input logic [NE-1:0] mask);
    int idx;
    idx = -1;
    for (int i = NE - 1; i >= 0; i--) if (mask[i]) idx = i;
    m_cause = exc_cause[32*idx +: 32] & 32'h7fff_ffff;
    m_epc = exc_pc[32*idx +: 32];
  endtask
  task automatic do_exc(input logic [NE-1:0] mask, input int ack, input bit mr);
    exc_valid = mask;
    irq_pending = 1'($urandom);
    mret_req = mr;
    capture_exc(mask);
    step();
    idle_inputs();
    finish_commit(0, 0, ack);
  endtask
  task automatic do_mret(input int ack);
    exc_valid = '0;
    irq_pending = 0;
    mret_req = 1;
    step();
    idle_inputs();
    finish_commit(1, 0, ack);
  endtask
  // mode 0: commit after drain; 1: irq drops at drain cycle k; 2: exception at cycle k
  task automatic do_irq(input logic [31:0] ic, input int w, input int mode, input int k,
                        input bit rnd_pc, input logic [31:0] rpc, input int eidx, input int ack);
    int nc;
    bit done;
    nc = (w > DC - 1) ? w : DC - 1;
    exc_valid = '0;
    irq_pending = 1;
    irq_cause = ic;
    pipe_idle = 0;
    mret_req = 1'($urandom);
    step();
    mret_req = 0;
    done = 0;
    for (int n = 0; n <= nc && !done; n++) begin
      check("drain_stall", b0.stall, 1);
      check("drain_busy", b0.busy, 1);
      check("drain_trap", b0.trap_commit, 0);
      check("drain_flush", b0.flush, 0);
      check_regs();
      pipe_idle = (n >= w);
      retire_pc = rnd_pc ? $urandom : rpc;
      if (mode == 1 && n == k) begin
        irq_pending = 0;
        done = 1;
      end else if (mode == 2 && n == k) begin
        exc_valid = NE'(($urandom << eidx) | (1 << eidx));
        exc_cause = {$urandom, $urandom, $urandom, $urandom};
        exc_pc = {$urandom, $urandom, $urandom, $urandom};
        capture_exc(exc_valid);
        done = 1;
      end else if (n == nc) begin
        m_cause = ic | 32'h8000_0000;
        m_epc = retire_pc;
        done = 1;
      end
      step();
    end
    idle_inputs();
    if (mode == 1) check_idle();
    else finish_commit(0, mode == 0, ack);
  endtask
  initial begin
    @(negedge clk);
    check("rst_busy", b0.busy, 0);
    check("rst_flush", b0.flush, 0);
    check("rst_trap", b0.trap_commit, 0);
    check_regs();
    reset = 0;
    step();
    check_idle();
    exc_cause = '0;
    exc_pc = '0;
    exc_cause[63:32] = 32'd2;
    exc_cause[95:64] = 32'd5;
    exc_pc[63:32] = 32'h100;
    exc_pc[95:64] = 32'h200;
    do_exc(4'b0110, 0, 0);
    do_irq(32'd11, 3, 0, 0, 0, 32'h444, 0, 1);
    do_irq(32'd11, 5, 2, 2, 1, 0, 3, 0);
    do_irq(32'd3, 6, 1, 3, 1, 0, 0, 0);
    do_mret(4);
    exc_cause[31:0] = 32'hffff_ffff;
    exc_pc[31:0] = 32'h5000;
    do_exc(4'b0001, 2, 1);
    do_irq(32'd7, 0, 0, 0, 1, 0, 0, 0);
    for (int t = 0; t < 300; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        exc_cause = {$urandom, $urandom, $urandom, $urandom};
        exc_pc = {$urandom, $urandom, $urandom, $urandom};
        do_exc(NE'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom));
      end else if (kind == 1) begin
        do_irq($urandom, $urandom_range(0, 4), 0, 0, 1, 0, 0, $urandom_range(0, 3));
      end else if (kind == 2) begin
        int w, nc;
        w = $urandom_range(0, 4);
        nc = (w > DC - 1) ? w : DC - 1;
        do_irq($urandom, w, $urandom_range(1, 2), $urandom_range(0, nc), 1, 0,
               $urandom_range(0, NE - 1), $urandom_range(0, 3));
      end else begin
        do_mret($urandom_range(0, 4));
      end
    end
    exc_cause = {$urandom, $urandom, $urandom, $urandom};
    exc_pc = {$urandom, $urandom, $urandom, $urandom};
    exc_valid = 4'b1000;
    capture_exc(exc_valid);
    step();
    idle_inputs();
    check("pre_rst_trap", b0.trap_commit, 1);
    #2 reset = 1;
    #1;
    m_count = 0;
    m_cause = '0;
    m_epc = '0;
    check("arst_trap", b0.trap_commit, 0);
    check("arst_stall", b0.stall, 0);
    check("arst_busy", b0.busy, 0);
    check("arst_irq", b0.trap_is_irq, 0);
    check_regs();
    #1 reset = 0;
    step();
    check_idle();
    do_exc(4'b0100, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
